// File: rtl/disp_pkg.sv
// disp_pkg: shared scan FSM state type, digit-enable patterns and default IO addresses
package disp_pkg;
  typedef enum logic {ST_SHOW = 1'b0, ST_BLANK = 1'b1} state_t;
  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] DISP_ADDR_DEF = 4'h0;
  localparam logic [3:0] STAT_ADDR_DEF = 4'h8;
endpackage

// File: rtl/display_scan_ctrl_digit_timer.sv
// digit_timer: 16-bit down-counter timing one scan phase, done pulses on the phase's last cycle
//   CLK, RESET   clock, asynchronous active-high reset
//   len_i        length in cycles of the phase currently running
//   done_o       high for exactly one cycle, the last cycle of the phase
module digit_timer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] len_i,
  output logic        done_o
);
  logic [15:0] cnt_q, cnt_d, rem;
  // a zero count means a phase is just starting, so the counter loads len_i implicitly
  assign rem = cnt_q == 16'd0 ? len_i : cnt_q;
  assign done_o = rem == 16'd1;
  assign cnt_d = done_o ? 16'd0 : rem - 16'd1;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed 7-segment scanner with frame-synchronous double-buffered data
//   CLK, RESET            clock, asynchronous active-high reset
//   IO_WR_EN/ADDR/WDATA   processor write port (DISP_ADDR loads pending data)
//   IO_RDATA              combinational readback of shadow or status
//   SEG, AN               active-low segment and digit drives
//   FRAME_TICK            one-cycle pulse on the first cycle of each frame
//   Macro DISP_SCAN_BLANK_EN inserts a blanking phase after every digit.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int          DIGIT_CYCLES = 16384,
  parameter int          BLANK_CYCLES = 256,
  parameter logic [3:0]  DISP_ADDR    = DISP_ADDR_DEF,
  parameter logic [3:0]  STAT_ADDR    = STAT_ADDR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IO_WR_EN,
  input  logic [3:0]  IO_ADDR,
  input  logic [31:0] IO_WDATA,
  output logic [31:0] IO_RDATA,
  output logic [6:0]  SEG,
  output logic [3:0]  AN,
  output logic        FRAME_TICK
);
  state_t      state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [27:0] shadow_q, shadow_d, pending_q, pending_d;
  logic        flag_q, flag_d, tick_q;
  logic        done, frame_end, wr, blank;
  logic [15:0] len;
  logic        unused_wdata;
  assign unused_wdata = ^IO_WDATA[31:28];
  assign len = state_q == ST_BLANK ? 16'(BLANK_CYCLES) : 16'(DIGIT_CYCLES);
  digit_timer u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .len_i  (len),
    .done_o (done)
  );
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q   <= ST_SHOW;
      digit_q   <= 2'd0;
      shadow_q  <= 28'd0;
      pending_q <= 28'd0;
      flag_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      flag_q    <= flag_d;
      tick_q    <= frame_end;
    end
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
`ifdef DISP_SCAN_BLANK_EN
    if (done) begin
      state_d = state_q == ST_SHOW ? ST_BLANK : ST_SHOW;
      digit_d = state_q == ST_BLANK ? digit_q + 2'd1 : digit_q;
    end
    frame_end = done && state_q == ST_BLANK && digit_q == 2'd3;
`else
    if (done) digit_d = digit_q + 2'd1;
    frame_end = done && digit_q == 2'd3;
`endif
    wr = IO_WR_EN && IO_ADDR == DISP_ADDR;
    pending_d = wr ? IO_WDATA[27:0] : pending_q;
    // transfer uses the value held before any coinciding write, which then stays pending
    shadow_d = frame_end && flag_q ? pending_q : shadow_q;
    flag_d = wr || (flag_q && !frame_end);
  end
  always_comb begin
`ifdef DISP_SCAN_BLANK_EN
    blank = state_q == ST_BLANK;
`else
    blank = 1'b0;
`endif
    AN = blank ? AN_OFF :
         digit_q == 2'd0 ? AN_D0 :
         digit_q == 2'd1 ? AN_D1 :
         digit_q == 2'd2 ? AN_D2 : AN_D3;
    SEG = blank ? 7'h7F : ~shadow_q[7*digit_q +: 7];
    IO_RDATA = IO_ADDR == DISP_ADDR ? {4'b0, shadow_q} :
               IO_ADDR == STAT_ADDR ? {28'b0, blank, digit_q, flag_q} : 32'h0;
    FRAME_TICK = tick_q;
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed self-checking bench for display_scan_ctrl (DIGIT=4, BLANK=2)
module tb_display_scan_ctrl;
  localparam int S = 4;
`ifdef DISP_SCAN_BLANK_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif
  localparam int P = S + BL;
  localparam int F = 4 * P;
  logic        CLK = 1'b0;
  logic        RESET, IO_WR_EN, FRAME_TICK;
  logic [3:0]  IO_ADDR, AN;
  logic [31:0] IO_WDATA, IO_RDATA, rdv;
  logic [6:0]  SEG;
  int checks = 0;
  int failures = 0;
  int pos = 0;
  always #5 CLK = ~CLK;
  display_scan_ctrl #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IO_WR_EN   (IO_WR_EN),
    .IO_ADDR    (IO_ADDR),
    .IO_WDATA   (IO_WDATA),
    .IO_RDATA   (IO_RDATA),
    .SEG        (SEG),
    .AN         (AN),
    .FRAME_TICK (FRAME_TICK)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] an_exp(input int p);
    int d;
    int o;
    logic [3:0] one;
    d = p / P;
    o = p % P;
    one = 4'b0001;
    return o < S ? ~(one << d) : 4'hF;
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
    pos = (pos + 1) % F;
  endtask
  task automatic goto(input int p);
    for (int i = 0; i < F && pos != p; i++) tick();
    chk("goto", pos, p);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    IO_WR_EN = 1'b1;
    IO_ADDR = a;
    IO_WDATA = d;
    tick();
    IO_WR_EN = 1'b0;
    IO_ADDR = 4'h8;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    IO_ADDR = a;
    #1;
    d = IO_RDATA;
  endtask
  initial begin
    RESET = 1'b1;
    IO_WR_EN = 1'b0;
    IO_ADDR = 4'h8;
    IO_WDATA = 32'h0;
    #2;
    chk("reset_an", AN, 4'hE);
    chk("reset_seg", SEG, 7'h7F);
    chk("reset_tick", FRAME_TICK, 1'b0);
    rd(4'h8, rdv);
    chk("reset_stat", rdv, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    pos = 0;
    for (int i = 0; i < F; i++) begin
      chk("scan_an", AN, an_exp(pos));
      chk("first_frame_tick", FRAME_TICK, 1'b0);
      tick();
    end
    chk("frame_tick", FRAME_TICK, 1'b1);
    chk("frame_wrap_an", AN, 4'hE);
    tick();
    chk("tick_one_cycle", FRAME_TICK, 1'b0);
    goto(S);
    rd(4'h8, rdv);
    chk("stat_phase", rdv, BL > 0 ? 32'h8 : 32'h2);
    wr(4'h0, 32'hF0ABCDEF);
    rd(4'h8, rdv);
    chk("stat_pending", rdv[0], 1'b1);
    rd(4'h0, rdv);
    chk("shadow_hold", rdv, 32'h0);
    goto(2 * P);
    chk("seg_hold", SEG, 7'h7F);
    goto(0);
    chk("write_tick", FRAME_TICK, 1'b1);
    chk("seg_d0", SEG, 7'h10);
    rd(4'h0, rdv);
    chk("disp_read", rdv, 32'h0ABCDEF);
    rd(4'h8, rdv);
    chk("pending_clear", rdv[0], 1'b0);
    goto(P);
    chk("seg_d1", SEG, 7'h64);
    goto(2 * P);
    chk("seg_d2", SEG, 7'h50);
    goto(3 * P);
    chk("seg_d3", SEG, 7'h7A);
    wr(4'h8, 32'h0FFFFFFF);
    wr(4'h3, 32'h01234567);
    rd(4'h8, rdv);
    chk("ignored_wr_flag", rdv[0], 1'b0);
    rd(4'h3, rdv);
    chk("other_addr_read", rdv, 32'h0);
    goto(0);
    rd(4'h0, rdv);
    chk("ignored_wr_disp", rdv, 32'h0ABCDEF);
    goto(2);
    wr(4'h0, 32'h01111111);
    wr(4'h0, 32'h02222222);
    rd(4'h0, rdv);
    chk("two_wr_hold", rdv, 32'h0ABCDEF);
    goto(0);
    rd(4'h0, rdv);
    chk("two_wr_last", rdv, 32'h2222222);
    chk("two_wr_seg", SEG, 7'h5D);
    goto(3);
    wr(4'h0, 32'h01111111);
    goto(F - 1);
    wr(4'h0, 32'h03333333);
    chk("edge_pos", pos, 0);
    rd(4'h0, rdv);
    chk("edge_old", rdv, 32'h1111111);
    chk("edge_seg", SEG, 7'h6E);
    rd(4'h8, rdv);
    chk("edge_still_pending", rdv[0], 1'b1);
    tick();
    goto(0);
    rd(4'h0, rdv);
    chk("edge_new", rdv, 32'h3333333);
    rd(4'h8, rdv);
    chk("edge_flag_clear", rdv[0], 1'b0);
    goto(1);
    wr(4'h0, 32'h05555555);
    goto(2 * P + S);
    RESET = 1'b1;
    #1;
    chk("rst_an", AN, 4'hE);
    chk("rst_seg", SEG, 7'h7F);
    chk("rst_tick", FRAME_TICK, 1'b0);
    rd(4'h0, rdv);
    chk("rst_disp", rdv, 32'h0);
    rd(4'h8, rdv);
    chk("rst_stat", rdv, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    pos = 0;
    for (int i = 0; i < F; i++) begin
      chk("rst_scan_an", AN, an_exp(pos));
      chk("rst_first_tick", FRAME_TICK, 1'b0);
      tick();
    end
    chk("rst_frame_tick", FRAME_TICK, 1'b1);
    rd(4'h0, rdv);
    chk("rst_shadow_zero", rdv, 32'h0);
    rd(4'h8, rdv);
    chk("rst_pending_gone", rdv, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
